alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: requester 0 is the pipeline execute stage, requester 1 is the auxiliary/debug unit.
- Arbitrates round-robin and registers the chosen operands into the ALU input ports.
- Captures the ALU result one cycle later and returns it on a shared response channel tagged with the requester ID.
- Sits between the requesters and the ALU instance; the ALU has no other drivers.

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the execute
// stage (requester 0) and the debug unit (requester 1), returning tagged results.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OS_W   = 3,
  parameter int SH_W   = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_sr1,
  input  logic [DATA_W-1:0] req0_sr2,
  input  logic [OS_W-1:0]   req0_os,
  input  logic [SH_W-1:0]   req0_shift,
  input  logic [DATA_W-1:0] req1_sr1,
  input  logic [DATA_W-1:0] req1_sr2,
  input  logic [OS_W-1:0]   req1_os,
  input  logic [SH_W-1:0]   req1_shift,
  output logic [DATA_W-1:0] alu_sr1,
  output logic [DATA_W-1:0] alu_sr2,
  output logic [OS_W-1:0]   alu_os,
  output logic [SH_W-1:0]   alu_shift,
  input  logic [DATA_W-1:0] alu_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rd,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_id;
  logic [DATA_W-1:0] r_alu_sr1;
  logic [DATA_W-1:0] r_alu_sr2;
  logic [OS_W-1:0]   r_alu_os;
  logic [SH_W-1:0]   r_alu_shift;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_rd;
  logic              r_rsp_zero;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_hs;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no input
    // pattern leaves a value held over and no latch is inferred.
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    case (req_valid)
      2'b01:   begin w_gnt_valid = 1'b1; w_gnt_id = 1'b0;          end
      2'b10:   begin w_gnt_valid = 1'b1; w_gnt_id = 1'b1;          end
      2'b11:   begin w_gnt_valid = 1'b1; w_gnt_id = ~r_last_grant; end
      default: ;
    endcase
  end

  // Ready is only offered while idle and out of reset, so a grant is never lost.
  assign req_ready = (r_state == ST_IDLE && !reset && w_gnt_valid)
                   ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign w_hs      = |(req_valid & req_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_alu_sr1    <= '0;
      r_alu_sr2    <= '0;
      r_alu_os     <= '0;
      r_alu_shift  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_rd     <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_alu_sr1    <= w_gnt_id ? req1_sr1   : req0_sr1;
            r_alu_sr2    <= w_gnt_id ? req1_sr2   : req0_sr2;
            r_alu_os     <= w_gnt_id ? req1_os    : req0_os;
            r_alu_shift  <= w_gnt_id ? req1_shift : req0_shift;
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_rd    <= alu_rd;
          r_rsp_zero  <= (alu_rd == '0);
          r_rsp_err   <= (r_alu_os == {OS_W{1'b1}});
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_sr1   = r_alu_sr1;
  assign alu_sr2   = r_alu_sr2;
  assign alu_os    = r_alu_os;
  assign alu_shift = r_alu_shift;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU drives alu_rd, and a transaction-level
// model predicts grant order, results, flags and the wrapping op counter.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 3;
  localparam int SW = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_sr1 = '0, req0_sr2 = '0, req1_sr1 = '0, req1_sr2 = '0;
  logic [OW-1:0] req0_os = '0, req1_os = '0;
  logic [SW-1:0] req0_shift = '0, req1_shift = '0;
  logic [DW-1:0] alu_sr1, alu_sr2, alu_rd, rsp_rd;
  logic [OW-1:0] alu_os;
  logic [SW-1:0] alu_shift;
  logic          rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] op_count;
  logic [115:0]  all_out;

  int   checks = 0;
  int   errors = 0;
  logic model_last = 1'b1;
  int   model_count = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .OS_W(OW), .SH_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_sr1(req0_sr1), .req0_sr2(req0_sr2), .req0_os(req0_os), .req0_shift(req0_shift),
    .req1_sr1(req1_sr1), .req1_sr2(req1_sr2), .req1_os(req1_os), .req1_shift(req1_shift),
    .alu_sr1(alu_sr1), .alu_sr2(alu_sr2), .alu_os(alu_os), .alu_shift(alu_shift),
    .alu_rd(alu_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rd(rsp_rd),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] os, input logic [SW-1:0] sh);
    case (os)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a ^ b;
      3'd4:    return a | b;
      3'd5:    return a << sh;
      3'd6:    return a >> sh;
      default: return '0;
    endcase
  endfunction

  assign alu_rd  = alu_f(alu_sr1, alu_sr2, alu_os, alu_shift);
  assign all_out = {req_ready, alu_sr1, alu_sr2, alu_os, alu_shift, rsp_valid, rsp_id,
                    rsp_rd, rsp_zero, rsp_err, busy, op_count};

  // Present a request, wait for its handshake and response, then accept it.
  // lat counts clock edges from the handshake edge (inclusive) to rsp_valid.
  task automatic transact(input logic [1:0] valid, input int stall, input bit hold,
                          input bit early, output logic id, output logic [DW-1:0] rd,
                          output logic zero, output logic err, output logic [1:0] rdy,
                          output int lat);
    int n;
    lat = -1; id = 1'b0; rd = '0; zero = 1'b0; err = 1'b0; rdy = 2'b00;
    req_valid = valid;
    @(negedge clk);
    n = 0;
    while (((req_ready & req_valid) == 2'b00) && n < 20) begin
      @(negedge clk);
      n++;
    end
    rdy = req_ready;
    if ((req_ready & req_valid) == 2'b00) begin
      req_valid = 2'b00;
      return;
    end
    @(posedge clk); #1;
    if (!hold) begin
      req_valid  = 2'b00;
      req0_sr1   = $urandom; req0_sr2 = $urandom; req0_os = OW'($urandom);
      req1_sr1   = $urandom; req1_sr2 = $urandom; req1_os = OW'($urandom);
      req0_shift = SW'($urandom); req1_shift = SW'($urandom);
    end
    if (early) rsp_ready = 1'b1;
    n = 1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 10);
    if (!rsp_valid) begin
      rsp_ready = 1'b0;
      return;
    end
    lat = n; id = rsp_id; rd = rsp_rd; zero = rsp_zero; err = rsp_err;
    if (!early) repeat (stall) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    req_valid = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", all_out);
    end
    reset = 1'b0;
    req_valid = 2'b00;
    model_last = 1'b1; model_count = 0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_single;
    logic id, zero, err; logic [DW-1:0] rd; logic [1:0] rdy; int lat;
    req0_sr1 = 32'd5; req0_sr2 = 32'd7; req0_os = 3'b000; req0_shift = '0;
    transact(2'b01, 0, 1'b0, 1'b0, id, rd, zero, err, rdy, lat);
    model_last = 1'b0; model_count = (model_count + 1) % 16;
    checks++;
    if (rdy !== 2'b01 || lat != 2) begin
      errors++;
      $display("FAIL single_hs req_ready=%b lat=%0d expected 01 2", rdy, lat);
    end
    checks++;
    if ({id, rd, zero, err} !== {1'b0, 32'd12, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp id=%b rd=%0d zero=%b err=%b expected 0 12 0 0", id, rd, zero, err);
    end
    checks++;
    if (op_count !== CW'(model_count)) begin
      errors++;
      $display("FAIL single_count got %0d expected %0d", op_count, model_count);
    end
  endtask

  task automatic test_fairness;
    logic id, zero, err, exp_id; logic [DW-1:0] rd; logic [1:0] rdy; int lat;
    req0_sr1 = 32'hF0; req0_sr2 = 32'h0F; req0_os = 3'b010;
    req1_sr1 = 32'hFF; req1_sr2 = 32'hFF; req1_os = 3'b011;
    for (int i = 0; i < 4; i++) begin
      exp_id = ~model_last;
      transact(2'b11, 0, 1'b1, 1'b0, id, rd, zero, err, rdy, lat);
      model_last = exp_id; model_count = (model_count + 1) % 16;
      checks++;
      if (id !== exp_id || lat != 2 || rd !== '0 || zero !== 1'b1) begin
        errors++;
        $display("FAIL fair_%0d id=%b lat=%0d rd=%h zero=%b expected %b 2 0 1", i, id, lat, rd, zero, exp_id);
      end
    end
    req_valid = 2'b00;
    checks++;
    if (op_count !== CW'(model_count)) begin
      errors++;
      $display("FAIL fair_count got %0d expected %0d", op_count, model_count);
    end
  endtask

  task automatic test_backpressure;
    logic [DW+2:0] snap; logic bad; logic [DW-1:0] r1;
    req0_sr1 = 32'd100; req0_sr2 = 32'd58; req0_os = 3'b001;
    r1 = 32'h0000_ABCD;
    req1_sr1 = r1; req1_sr2 = 32'h1; req1_os = 3'b100;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(posedge clk); #1;
    model_last = 1'b0;
    snap = {rsp_valid, rsp_id, rsp_rd, rsp_zero};
    checks++;
    if (snap !== {1'b1, 1'b0, 32'd42, 1'b0}) begin
      errors++;
      $display("FAIL bp_rsp got %h expected valid=1 id=0 rd=42 zero=0", snap);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bad = ({rsp_valid, rsp_id, rsp_rd, rsp_zero} !== snap) || req_ready !== 2'b00 || busy !== 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL bp_hold_%0d rsp=%h ready=%b busy=%b expected %h 00 1",
                 i, {rsp_valid, rsp_id, rsp_rd, rsp_zero}, req_ready, busy, snap);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_count = (model_count + 1) % 16;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10 || op_count !== CW'(model_count)) begin
      errors++;
      $display("FAIL bp_release valid=%b ready=%b count=%0d expected 0 10 %0d",
               rsp_valid, req_ready, op_count, model_count);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (busy !== 1'b1 || alu_sr1 !== r1) begin
      errors++;
      $display("FAIL bp_accept1 busy=%b alu_sr1=%h expected 1 %h", busy, alu_sr1, r1);
    end
    @(posedge clk); #1;
    model_last = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_rd !== (r1 | 32'h1)) begin
      errors++;
      $display("FAIL bp_rsp1 valid=%b id=%b rd=%h expected 1 1 %h", rsp_valid, rsp_id, rsp_rd, r1 | 32'h1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_count = (model_count + 1) % 16;
  endtask

  task automatic test_error;
    logic id, zero, err; logic [DW-1:0] rd; logic [1:0] rdy; int lat;
    req1_sr1 = 32'h1234; req1_sr2 = $urandom; req1_os = 3'b111; req1_shift = SW'($urandom);
    transact(2'b10, 2, 1'b0, 1'b1, id, rd, zero, err, rdy, lat);
    model_last = 1'b1; model_count = (model_count + 1) % 16;
    checks++;
    if ({id, rd, zero, err} !== {1'b1, 32'd0, 1'b1, 1'b1} || lat != 2) begin
      errors++;
      $display("FAIL err_rsp id=%b rd=%h zero=%b err=%b lat=%0d expected 1 0 1 1 2", id, rd, zero, err, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic id, zero, err; logic [DW-1:0] rd; logic [1:0] rdy; int lat; logic bad;
    for (int stage = 1; stage <= 2; stage++) begin
      req0_sr1 = $urandom; req0_sr2 = $urandom; req0_os = 3'b000;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      if (stage == 2) begin
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_pre rsp_valid=%b expected 1", rsp_valid);
        end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL rstmid_%0d outputs got %h expected 0", stage, all_out);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      bad = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rstmid_quiet_%0d spurious activity got 1 expected 0", stage);
      end
    end
    model_last = 1'b1; model_count = 0;
    req0_sr1 = 32'd3; req0_sr2 = 32'd4; req0_os = 3'b000;
    req1_sr1 = 32'd9; req1_sr2 = 32'd9; req1_os = 3'b001;
    transact(2'b11, 0, 1'b0, 1'b0, id, rd, zero, err, rdy, lat);
    model_last = 1'b0; model_count = 1;
    checks++;
    if (id !== 1'b0 || rd !== 32'd7 || op_count !== 4'd1) begin
      errors++;
      $display("FAIL rstmid_tie id=%b rd=%0d count=%0d expected 0 7 1", id, rd, op_count);
    end
  endtask

  task automatic test_random(input int n_ops);
    logic id, zero, err, exp_id; logic [DW-1:0] rd, exp_rd; logic [1:0] rdy, v; int lat;
    logic [OW-1:0] eos;
    for (int i = 0; i < n_ops; i++) begin
      v = 2'($urandom_range(1, 3));
      req0_sr1 = $urandom; req0_sr2 = $urandom; req0_os = OW'($urandom); req0_shift = SW'($urandom);
      req1_sr1 = $urandom; req1_sr2 = $urandom; req1_os = OW'($urandom); req1_shift = SW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        req0_sr2 = req0_sr1; req0_os = 3'b011;
      end
      exp_id = (v == 2'b11) ? ~model_last : v[1];
      exp_rd = exp_id ? alu_f(req1_sr1, req1_sr2, req1_os, req1_shift)
                      : alu_f(req0_sr1, req0_sr2, req0_os, req0_shift);
      eos    = exp_id ? req1_os : req0_os;
      transact(v, $urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)), id, rd, zero, err, rdy, lat);
      model_last = exp_id; model_count = (model_count + 1) % 16;
      checks++;
      if (id !== exp_id || rd !== exp_rd || zero !== (exp_rd == '0) || err !== (eos == 3'b111) || lat != 2) begin
        errors++;
        $display("FAIL rand_%0d id=%b rd=%h zero=%b err=%b lat=%0d expected %b %h %b %b 2",
                 i, id, rd, zero, err, lat, exp_id, exp_rd, exp_rd == '0, eos == 3'b111);
      end
      checks++;
      if (op_count !== CW'(model_count)) begin
        errors++;
        $display("FAIL rand_count_%0d got %0d expected %0d", i, op_count, model_count);
      end
    end
  endtask

  task automatic test_wrap;
    logic id, zero, err; logic [DW-1:0] rd; logic [1:0] rdy; int lat;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_last = 1'b1; model_count = 0;
    for (int i = 1; i <= 16; i++) begin
      req0_sr1 = $urandom; req1_sr1 = $urandom;
      transact(2'($urandom_range(1, 3)), 0, 1'b0, 1'b0, id, rd, zero, err, rdy, lat);
      model_count = (model_count + 1) % 16;
      if (i == 15 || i == 16) begin
        checks++;
        if (op_count !== CW'(model_count) || lat != 2) begin
          errors++;
          $display("FAIL wrap_%0d count=%0d lat=%0d expected %0d 2", i, op_count, lat, model_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_random(30);
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
